// File: rtl/i2f_share_arb.sv
// Round-robin share of one int64 -> recF32 converter among NREQ requesters,
// with in-order, credit-protected response return. Optional perf counters: I2F_PERF_CNT_EN.
module i2f_share_arb #(
   parameter int NREQ       = 4,
   parameter int LATENCY    = 1,
   parameter int RESP_DEPTH = 4,
   parameter int TAG_W      = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*64-1:0]     req_in,
   input  logic [NREQ-1:0]        req_signed,
   input  logic [NREQ*2-1:0]      req_rm,
   input  logic [NREQ*TAG_W-1:0]  req_tag,
   output logic                   conv_signedIn,
   output logic [63:0]            conv_in,
   output logic [1:0]             conv_roundingMode,
   input  logic [32:0]            conv_out,
   input  logic [4:0]             conv_flags,
   output logic [NREQ-1:0]        resp_valid,
   input  logic [NREQ-1:0]        resp_ready,
   output logic [32:0]            resp_out,
   output logic [4:0]             resp_flags,
   output logic [TAG_W-1:0]       resp_tag,
   output logic                   busy
`ifdef I2F_PERF_CNT_EN
   ,
   output logic [31:0]            perf_issued,
   output logic [31:0]            perf_inexact
`endif
);

   localparam int IDW = $clog2(NREQ);
   localparam int AW  = $clog2(RESP_DEPTH);
   localparam int CW  = $clog2(RESP_DEPTH + 1);
   localparam logic [IDW:0]  NREQ_W  = (IDW+1)'(NREQ);
   localparam logic [CW-1:0] DEPTH_W = CW'(RESP_DEPTH);

   typedef struct packed {
      logic [IDW-1:0]   id;
      logic [TAG_W-1:0] tag;
      logic [4:0]       flags;
      logic [32:0]      res;
   } ent_t;

   logic [IDW-1:0]   rr_q, rr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             grant_found;
   logic [IDW-1:0]   grant_id;
   logic [IDW:0]     scan_idx;
   logic             accept;
   logic [63:0]      sel_in;
   logic             sel_sgn;
   logic [1:0]       sel_rm;
   logic [TAG_W-1:0] sel_tag;

   logic             s0_vld_q;
   logic [63:0]      s0_in_q;
   logic             s0_sgn_q;
   logic [1:0]       s0_rm_q;
   logic [TAG_W-1:0] s0_tag_q;
   logic [IDW-1:0]   s0_id_q;

   logic [LATENCY:1] st_vld_q;
   ent_t             st_q [1:LATENCY];

   ent_t             fifo_mem [RESP_DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    fifo_cnt_q, fifo_cnt_d;
   logic             fifo_ne;
   logic             wr_en;
   logic             pop;
   ent_t             head;

   // Scan offsets high to low so the requester closest to rr_q wins.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      scan_idx    = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         scan_idx = {1'b0, rr_q} + (IDW+1)'(k);
         if (scan_idx >= NREQ_W) scan_idx = scan_idx - NREQ_W;
         if (req_valid[scan_idx[IDW-1:0]]) begin
            grant_found = 1'b1;
            grant_id    = scan_idx[IDW-1:0];
         end
      end
   end

   assign accept = reset & grant_found & (count_q < DEPTH_W);

   always_comb begin
      sel_in  = '0;
      sel_sgn = 1'b0;
      sel_rm  = '0;
      sel_tag = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (grant_id == IDW'(k)) begin
            sel_in  = req_in[k*64 +: 64];
            sel_sgn = req_signed[k];
            sel_rm  = req_rm[k*2 +: 2];
            sel_tag = req_tag[k*TAG_W +: TAG_W];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_port
         assign req_ready[gi]  = accept & (grant_id == IDW'(gi));
         assign resp_valid[gi] = fifo_ne & (head.id == IDW'(gi));
      end
   endgenerate

   always_comb begin
      rr_d = rr_q;
      if (accept) rr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
   end

   always_comb begin
      count_d = count_q;
      if (accept && !pop)      count_d = count_q + 1'b1;
      else if (!accept && pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rr_q     <= '0;
         count_q  <= '0;
         s0_vld_q <= 1'b0;
         s0_in_q  <= '0;
         s0_sgn_q <= 1'b0;
         s0_rm_q  <= '0;
         s0_tag_q <= '0;
         s0_id_q  <= '0;
      end else begin
         rr_q     <= rr_d;
         count_q  <= count_d;
         s0_vld_q <= accept;
         if (accept) begin
            s0_in_q  <= sel_in;
            s0_sgn_q <= sel_sgn;
            s0_rm_q  <= sel_rm;
            s0_tag_q <= sel_tag;
            s0_id_q  <= grant_id;
         end
      end
   end

   assign conv_in           = s0_in_q;
   assign conv_signedIn     = s0_sgn_q;
   assign conv_roundingMode = s0_rm_q;

   // Result pipeline: payload needs no reset, only the valid bits do.
   always_ff @(posedge clk) begin
      st_q[1] <= {s0_id_q, s0_tag_q, conv_flags, conv_out};
      for (int k = LATENCY; k >= 2; k--) st_q[k] <= st_q[k-1];
      if (!reset) begin
         st_vld_q <= '0;
      end else begin
         st_vld_q[1] <= s0_vld_q;
         for (int k = LATENCY; k >= 2; k--) st_vld_q[k] <= st_vld_q[k-1];
      end
   end

   assign wr_en   = st_vld_q[LATENCY];
   assign fifo_ne = (fifo_cnt_q != '0);
   assign head    = fifo_mem[rd_ptr_q];
   assign pop     = |(resp_valid & resp_ready);

   always_comb begin
      fifo_cnt_d = fifo_cnt_q;
      if (wr_en && !pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
      else if (!wr_en && pop) fifo_cnt_d = fifo_cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (wr_en) fifo_mem[wr_ptr_q] <= st_q[LATENCY];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         fifo_cnt_q <= fifo_cnt_d;
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   assign resp_out   = head.res;
   assign resp_flags = head.flags;
   assign resp_tag   = head.tag;
   assign busy       = (count_q != '0);

`ifdef I2F_PERF_CNT_EN
   logic [31:0] perf_issued_q, perf_inexact_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         perf_issued_q  <= '0;
         perf_inexact_q <= '0;
      end else begin
         if (accept)                perf_issued_q  <= perf_issued_q + 1'b1;
         if (pop && head.flags[0])  perf_inexact_q <= perf_inexact_q + 1'b1;
      end
   end

   assign perf_issued  = perf_issued_q;
   assign perf_inexact = perf_inexact_q;
`endif

endmodule

// File: tb/tb_i2f_share_arb.sv
// Self-checking bench for i2f_share_arb: directed scenarios plus random traffic
// against a queue-based scoreboard and a behavioural int64 -> recF32 converter.
module tb_i2f_share_arb;

   localparam int NREQ  = 4;
   localparam int LAT   = 1;
   localparam int DEPTH = 4;
   localparam int TAG_W = 5;

   logic               clk = 1'b0;
   logic               reset;
   logic [NREQ-1:0]    req_valid, req_ready, req_signed, resp_valid, resp_ready;
   logic [NREQ*64-1:0] req_in;
   logic [NREQ*2-1:0]  req_rm;
   logic [NREQ*TAG_W-1:0] req_tag;
   logic               conv_signedIn;
   logic [63:0]        conv_in;
   logic [1:0]         conv_roundingMode;
   logic [32:0]        conv_out, resp_out;
   logic [4:0]         conv_flags, resp_flags;
   logic [TAG_W-1:0]   resp_tag;
   logic               busy;
`ifdef I2F_PERF_CNT_EN
   logic [31:0]        perf_issued, perf_inexact;
`endif

   i2f_share_arb #(.NREQ(NREQ), .LATENCY(LAT), .RESP_DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_in(req_in),
      .req_signed(req_signed), .req_rm(req_rm), .req_tag(req_tag),
      .conv_signedIn(conv_signedIn), .conv_in(conv_in), .conv_roundingMode(conv_roundingMode),
      .conv_out(conv_out), .conv_flags(conv_flags),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_out(resp_out),
      .resp_flags(resp_flags), .resp_tag(resp_tag), .busy(busy)
`ifdef I2F_PERF_CNT_EN
      , .perf_issued(perf_issued), .perf_inexact(perf_inexact)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural converter: returns {flags[4:0], recF32[32:0]}.
   function automatic logic [37:0] i2rec(input logic [63:0] x, input logic sgn, input logic [1:0] rm);
      logic neg, up, inexact;
      logic [63:0] mag, keep, rem, half;
      logic [8:0] ex;
      int p;
      neg = sgn & x[63];
      mag = neg ? (~x + 64'd1) : x;
      if (mag == 64'd0) return '0;
      p = 63;
      while (!mag[p]) p--;
      if (p <= 23) begin
         keep = mag << (23 - p);
         rem  = 64'd0;
         half = 64'd0;
      end else begin
         keep = mag >> (p - 23);
         rem  = mag & ((64'd1 << (p - 23)) - 64'd1);
         half = 64'd1 << (p - 24);
      end
      inexact = (rem != 64'd0);
      case (rm)
         2'b00:   up = inexact && (rem > half || (rem == half && keep[0]));
         2'b01:   up = 1'b0;
         2'b10:   up = neg && inexact;
         default: up = !neg && inexact;
      endcase
      keep = keep + 64'(up);
      if (keep[24]) begin
         keep = keep >> 1;
         p++;
      end
      ex = 9'(p + 256);
      return {4'b0, inexact, neg, ex, keep[22:0]};
   endfunction

   assign {conv_flags, conv_out} = i2rec(conv_in, conv_signedIn, conv_roundingMode);

   typedef struct {
      int          id;
      logic [4:0]  tag;
      logic [37:0] res;
      int          due;
   } exp_t;

   exp_t q[$];
   int   rr, cyc, n_acc, m_issued, m_inexact;
   int   n_pass = 0, n_total = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic [63:0] x, input logic s,
                          input logic [1:0] rm, input logic [4:0] tag);
      req_valid[i]             = v;
      req_in[i*64 +: 64]       = x;
      req_signed[i]            = s;
      req_rm[i*2 +: 2]         = rm;
      req_tag[i*TAG_W +: TAG_W] = tag;
   endtask

   // One clock: check outputs at the falling edge against the scoreboard,
   // then advance the scoreboard by what the next rising edge will do.
   task automatic cycle();
      int g;
      logic [NREQ-1:0] exp_ready, exp_rv;
      logic hv;
      exp_t e;
      @(negedge clk);
      if (!reset) begin
         chk("reset_req_ready", 64'(req_ready), 64'd0);
         @(posedge clk);
         q.delete();
         rr = 0;
         m_issued = 0;
         m_inexact = 0;
         cyc++;
         #1;
         return;
      end
      g = -1;
      for (int k = 0; k < NREQ; k++)
         if (g < 0 && req_valid[(rr + k) % NREQ]) g = (rr + k) % NREQ;
      exp_ready = '0;
      if (g >= 0 && q.size() < DEPTH) exp_ready[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      hv = (q.size() > 0) && (cyc >= q[0].due);
      exp_rv = '0;
      if (hv) exp_rv[q[0].id] = 1'b1;
      chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
      if (hv) begin
         chk("resp_out", 64'(resp_out), 64'(q[0].res[32:0]));
         chk("resp_flags", 64'(resp_flags), 64'(q[0].res[37:33]));
         chk("resp_tag", 64'(resp_tag), 64'(q[0].tag));
      end
      chk("busy", 64'(busy), 64'(q.size() != 0));
      if (hv && resp_ready[q[0].id]) begin
         if (q[0].res[33]) m_inexact++;
         void'(q.pop_front());
      end
      if (exp_ready != '0) begin
         e.id  = g;
         e.tag = req_tag[g*TAG_W +: TAG_W];
         e.res = i2rec(req_in[g*64 +: 64], req_signed[g], req_rm[g*2 +: 2]);
         e.due = cyc + LAT + 2;
         q.push_back(e);
         rr = (g + 1) % NREQ;
         n_acc++;
         m_issued++;
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic drain();
      req_valid  = '0;
      resp_ready = '1;
      for (int k = 0; k < 40 && q.size() > 0; k++) cycle();
      cycle();
      chk("drain_busy", 64'(busy), 64'd0);
   endtask

   function automatic logic [63:0] rand_op();
      case ($urandom_range(0, 5))
         0:       return 64'($urandom_range(0, 300));
         1:       return {32'd0, $urandom};
         2:       return {$urandom, $urandom};
         3:       return 64'h8000_0000_0000_0000;
         4:       return '1;
         default: return 64'h0000_0000_0100_0000 | 64'($urandom_range(0, 3));
      endcase
   endfunction

   int acc_before;

   initial begin
      rr = 0; cyc = 0; n_acc = 0; m_issued = 0; m_inexact = 0;
      req_valid = '1; req_in = '0; req_signed = '0; req_rm = '0; req_tag = '0;
      resp_ready = '0;
      reset = 1'b0;
      cycle();
      cycle();
      reset = 1'b1;
      req_valid = '0;
      #1;
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_conv_in", conv_in, 64'd0);
      chk("rst_conv_rm", 64'({conv_signedIn, conv_roundingMode}), 64'd0);

      // Single conversion of 1 from requester 0: visible three cycles after accept.
      set_req(0, 1'b1, 64'd1, 1'b0, 2'b00, 5'd3);
      cycle();
      req_valid = '0;
      cycle();
      cycle();
      chk("t1_resp_valid", 64'(resp_valid), 64'b0001);
      chk("t1_resp_out", 64'(resp_out), 64'h0_8000_0000);
      chk("t1_resp_flags", 64'(resp_flags), 64'd0);
      chk("t1_resp_tag", 64'(resp_tag), 64'd3);
      chk("t1_busy", 64'(busy), 64'd1);
      resp_ready = '1;
      cycle();
      chk("t1_busy_after_pop", 64'(busy), 64'd0);

      // 2^24+1 is a tie: minMag truncates, max rounds up; both inexact.
      set_req(1, 1'b1, 64'h0000_0000_0100_0001, 1'b0, 2'b01, 5'd7);
      cycle();
      set_req(1, 1'b1, 64'h0000_0000_0100_0001, 1'b0, 2'b11, 5'd8);
      cycle();
      req_valid = '0;
      cycle();
      chk("t2_minmag_valid", 64'(resp_valid), 64'b0010);
      chk("t2_minmag_out", 64'(resp_out), 64'h0_8C00_0000);
      chk("t2_minmag_flags", 64'(resp_flags), 64'h01);
      chk("t2_minmag_tag", 64'(resp_tag), 64'd7);
      cycle();
      chk("t2_max_out", 64'(resp_out), 64'h0_8C00_0001);
      chk("t2_max_flags", 64'(resp_flags), 64'h01);
      chk("t2_max_tag", 64'(resp_tag), 64'd8);
      drain();

      // Everyone requesting, all responses accepted: one grant per cycle in rotation.
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 64'(1000 * (i + 1) + 7), 1'b0, 2'(i), 5'(i));
      resp_ready = '1;
      acc_before = n_acc;
      repeat (12) cycle();
      chk("t3_accepts", 64'(n_acc - acc_before), 64'd12);
      drain();

      // Back-pressure: credits limit outstanding work to DEPTH.
      req_valid  = '1;
      resp_ready = '0;
      acc_before = n_acc;
      repeat (8) cycle();
      chk("t4_accepts", 64'(n_acc - acc_before), 64'(DEPTH));
      chk("t4_ready_low", 64'(req_ready), 64'd0);
      resp_ready = '1;
      repeat (8) cycle();
      drain();

      // Reset with conversions in flight: nothing may emerge afterwards.
      req_valid  = '1;
      resp_ready = '0;
      repeat (3) cycle();
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      req_valid = '0;
      #1;
      chk("t5_resp_valid", 64'(resp_valid), 64'd0);
      chk("t5_busy", 64'(busy), 64'd0);
`ifdef I2F_PERF_CNT_EN
      chk("t5_perf_issued", 64'(perf_issued), 64'd0);
      chk("t5_perf_inexact", 64'(perf_inexact), 64'd0);
`endif
      resp_ready = '1;
      repeat (6) cycle();
      req_valid = '1;
      #1;
      chk("t5_rr_restart", 64'(req_ready), 64'b0001);
      cycle();
      drain();

      // Random traffic against the scoreboard.
      repeat (400) begin
         for (int i = 0; i < NREQ; i++)
            set_req(i, 1'($urandom_range(0, 3) != 0), rand_op(), 1'($urandom),
                    2'($urandom), 5'($urandom));
         resp_ready = 4'($urandom);
         cycle();
      end
      drain();
`ifdef I2F_PERF_CNT_EN
      chk("perf_issued", 64'(perf_issued), 64'(m_issued));
      chk("perf_inexact", 64'(perf_inexact), 64'(m_inexact));
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/i2f_share_arb.md
Name: i2f_share_arb

Overview:
- Shares one integer-to-recoded-float converter (64-bit int in, 33-bit recFN single out, 5-bit flags) among NREQ requesters.
- Round-robin arbitration with valid/ready handshake per requester.
- Registers converter operands, pipelines results over LATENCY stages, and returns them through a credit-protected response FIFO.
- Sits between the FPU issue ports (int-to-float moves from integer pipes) and the shared converter instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- LATENCY, 1, register stages after the operand register (1..4)
- RESP_DEPTH, 4, response FIFO entries; also the max outstanding conversions (>= LATENCY+1, power of 2)
- TAG_W, 5, requester tag width returned with the result

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- req_in  in  NREQ*64  operands, requester i at [64i+63:64i]
- req_signed  in  NREQ  operand is signed
- req_rm  in  NREQ*2  rounding mode: 00 RNE, 01 minMag, 10 min, 11 max
- req_tag  in  NREQ*TAG_W  tag
- conv_signedIn  out  1  to converter
- conv_in  out  64  to converter
- conv_roundingMode  out  2  to converter
- conv_out  in  33  converter result (combinational from conv_*)
- conv_flags  in  5  converter flags; bit0 = inexact, others 0
- resp_valid  out  NREQ  one-hot: destination of FIFO head
- resp_ready  in  NREQ  per-requester response accept
- resp_out  out  33  FIFO head result
- resp_flags  out  5  FIFO head flags
- resp_tag  out  TAG_W  FIFO head tag
- busy  out  1  outstanding count != 0

Behaviour:
- Reset (reset==0 at posedge) has these effects:
  - all pipeline valids cleared, FIFO emptied, credit count = 0, RR pointer = 0
  - conv_* = 0, resp_valid = 0, req_ready = 0, busy = 0
  - in-flight conversions are discarded; no response is ever produced for them.
- Arbitration:
  - Grant is the first requester with req_valid, scanning from RR pointer upward, modulo NREQ.
  - req_ready[g] = 1 only for grant g and only when count < RESP_DEPTH.
  - On acceptance (req_valid[g] & req_ready[g]), the pointer becomes (g+1) mod NREQ.
  - With no acceptance, the pointer holds.
  - req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
- Pipeline:
  - At acceptance on edge t, stage s0 latches operand, signed, rm, tag, and requester id; s0 drives conv_* during cycle t+1.
  - conv_out/conv_flags are captured into s1, then shift to sLATENCY; sLATENCY writes the FIFO.
  - Accept-to-resp_valid latency is LATENCY+2 cycles with an empty FIFO (3 at default).
  - The pipeline never stalls; credits guarantee FIFO space.
  - When s0 is empty, conv_* hold the last value (no toggling requirement).
- Credits:
  - count = pipeline occupancy + FIFO occupancy.
  - +1 on accept, -1 on pop; simultaneous accept and pop leaves count unchanged.
  - count never exceeds RESP_DEPTH.
- Response:
  - resp_valid[id of head] = 1 while the FIFO is non-empty.
  - Pop happens on resp_valid[i] & resp_ready[i].
  - Responses are strictly in issue order; head-of-line blocking is accepted.
  - resp_* are stable while not popped.
- FIFO full and a pop in the same cycle as an sLATENCY write: both occur, occupancy unchanged.
- FIFO pointers wrap modulo RESP_DEPTH.

Optional Feature:
- Macro: I2F_PERF_CNT_EN.
- When defined, the block adds output ports perf_issued[31:0] and perf_inexact[31:0]:
  - perf_issued counts acceptances.
  - perf_inexact counts FIFO pops with flags[0]=1.
  - Both counters wrap at 2^32 and clear on reset.
- When undefined, neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- Req0 in=64'd1, unsigned, rm=00, tag=3, accepted at cycle 0 -> resp_valid=4'b0001 at cycle 3, resp_out=33'h0_8000_0000, flags=0, tag=3, busy falls after pop.
- Req1 in=64'h0000_0000_0100_0001, rm=01 -> resp_out truncated (mantissa 0), resp_flags=5'h01; same operand with rm=11 -> mantissa 1 (rounded up), flags 5'h01.
- All 4 requesters valid continuously, resp_ready all 1 -> grants cycle 0,1,2,3,0,... one per cycle; responses arrive in the same order.
- resp_ready all 0, continuous requests -> exactly RESP_DEPTH=4 accepts, then req_ready=0; raising resp_ready[head] restores one accept per pop.
- Reset driven low for 1 cycle with 3 conversions in flight -> resp_valid=0, busy=0 next cycle; no stale responses emerge afterwards; RR restarts at requester 0.
- With I2F_PERF_CNT_EN: 10 accepts, 4 inexact -> perf_issued=10, perf_inexact=4 after drain.
